alu_exec: RTL and testbench
===========================

# alu_exec

Execute-stage wrapper sitting directly downstream of the decode/issue logic and around the combinational `alu`. It accepts one operation per valid/ready handshake, evaluates single-cycle ops through an instantiated `alu`, and runs `ALU_DIV` ops (signed or unsigned) on an iterative restoring divider. Result and flags are presented on a registered, back-pressurable output port to writeback.

## Interface
- `N`, default 8: operand/result width in bits (≥ 2).

- `clk`  in  1  sole clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  issue offers an operation.
- `in_ready`  out  1  block accepts this cycle; transfer when `in_valid && in_ready`.
- `in_op`  in  6  ALU opcode (`ALU_*` codes, optionally OR'd with `ALU_SIGNED`).
- `in_a`  in  N  operand a (dividend for DIV).
- `in_b`  in  N  operand b (divisor for DIV).
- `in_cin`  in  1  carry-in passed to `alu`.
- `out_valid`  out  1  result register holds an unconsumed result.
- `out_ready`  in  1  writeback consumes; transfer when `out_valid && out_ready`.
- `out_result`  out  N  result.
- `out_cout`, `out_overflow`, `out_sign`, `out_zero`  out  1 each  flags.
- `busy`  out  1  high while a divide is in progress.

## Operation
- States: IDLE, DIV, FIX. Reset → IDLE; all outputs, including `out_valid` and `busy`, are 0.
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`; a result is never overwritten before it is consumed.
- Non-DIV accept in IDLE: `alu` is driven combinationally from `in_*`; its `out` and flags are registered into the output register; `out_valid` is set.
- DIV accept in IDLE: latch divisor/dividend magnitudes (two's-complement absolute value when `ALU_SIGNED` is set, raw otherwise), the quotient sign (`a[N-1] ^ b[N-1]` when signed), and the opcode. Go to DIV, with `busy` = 1 and the iteration counter = N-1.
- DIV: one restoring step per cycle, with an N-bit remainder plus 1 guard bit. Shift in the next dividend MSB, trial-subtract, and set the quotient bit on no borrow. Go to FIX after N steps.
- FIX: negate the quotient if the sign flag is set. Load the output register, set `out_valid`, clear `busy`, go to IDLE.
- Signed division truncates toward zero; the remainder is discarded.
- Divide by zero: result is all ones, `out_overflow` = 1.
- Signed most-negative / −1: result is the most-negative value, `out_overflow` = 1.
- DIV flags: `zero` = (result == 0), `sign` = result[N-1], `cout` = 0, `overflow` as above, otherwise 0.
- Output register and flags hold stable while `out_valid && !out_ready`.
- `out_valid` clears on a consumption with no simultaneous new load. A consume and a new non-DIV load in the same cycle leave `out_valid` = 1 with the new data.
- `reset` at any point, including mid-DIV, aborts the operation: IDLE, `busy` = 0, `out_valid` = 0, and no result is produced.

## Timing
- Non-DIV: accept on edge T → `out_valid` after edge T+1. Throughput is 1/cycle when `out_ready` is held high.
- DIV: accept on edge T → `busy` high for cycles T+1..T+N+1 → `out_valid` after edge T+N+2. `in_ready` = 0 during DIV and FIX.
- Back-pressure has zero bubble: a consume and an accept may share a cycle.
- There are no combinational paths from `out_ready` to `out_*` data. `in_ready` depends combinationally on `out_ready`.

## Structure
- `ALU_*` opcode defines (`ALU_ADD`, `ALU_SUB`, `ALU_LSL`, `ALU_LSR`, `ALU_ASR`, `ALU_MUL`, `ALU_DIV`, `ALU_SIGNED`) stay in the shared ALU defines include, which both `alu` and `alu_exec` use.
- The state encodings are local to this block.
- Instantiates `alu #(N)` unchanged.
- One natural sub-module, `div_iter`: the magnitude restoring divider with a start/done handshake. Sign fix-up, DIV flags and the output register stay in `alu_exec`.

## Test plan
- Unsigned ADD, N=8:
  - 255 + 1 → result 0, `zero` = 1, `cout` = 1, `out_valid` one cycle after accept.
  - Back-to-back 1+1, then 127+127 with `out_ready` = 1 → results 2 and 254 on consecutive cycles.
- Signed DIV:
  - −7 / 3 → −2 (0xFE), `sign` = 1, `out_valid` exactly N+2 = 10 cycles after accept, `busy` high for cycles T+1 through T+9, `in_ready` low throughout.
  - Unsigned 200 / 7 → 28.
  - −128 / −1 signed → −128, `overflow` = 1.
  - 5 / 0 → 0xFF, `overflow` = 1.
- Back-pressure: hold `out_ready` = 0 after LSL 0b00111010 by 2 → `out_result` stays 0b11101000 and `in_ready` stays 0 for 5 cycles; raising `out_ready` with a pending SUB 1−2 accepts in the same cycle → next result 255, `cout` per `alu`.
- Reset mid-DIV: assert `reset` 4 cycles into 100 / 3 → next cycle `busy` = 0, `out_valid` = 0, `in_ready` = 1; no result ever appears for it.
- Signed MUL (−3)×7 → −21, `overflow` = 0. ASR 0b10111010 by 2 → 0b11101110.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Opcodes shared by alu and alu_exec, plus the execute-stage state type.
package alu_exec_pkg;

  localparam logic [5:0] ALU_ADD    = 6'h00;
  localparam logic [5:0] ALU_SUB    = 6'h01;
  localparam logic [5:0] ALU_LSL    = 6'h02;
  localparam logic [5:0] ALU_LSR    = 6'h03;
  localparam logic [5:0] ALU_ASR    = 6'h04;
  localparam logic [5:0] ALU_MUL    = 6'h05;
  localparam logic [5:0] ALU_DIV    = 6'h06;
  localparam logic [5:0] ALU_SIGNED = 6'h20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } exec_state_e;

  // Opcode with the signedness modifier stripped.
  function automatic logic [5:0] op_base(input logic [5:0] op);
    return op & ~ALU_SIGNED;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub with carry, shifts, low-half multiply, with flags.
module alu
  import alu_exec_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [5:0]   i_op,
  input  logic         i_cin,
  output logic [N-1:0] o_out,
  output logic         o_cout,
  output logic         o_overflow,
  output logic         o_sign,
  output logic         o_zero
);

  logic         w_sgn;
  logic [N:0]   w_sum;
  logic [N:0]   w_dif;
  logic [2*N-1:0] w_ma;
  logic [2*N-1:0] w_mb;
  logic [2*N-1:0] w_prod;

  assign w_sgn  = (i_op & ALU_SIGNED) != 6'h00;
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
  // cout on SUB is the carry of a + ~b + 1, i.e. 1 when no borrow
  assign w_dif  = {1'b0, i_a} + {1'b0, ~i_b} + {{N{1'b0}}, 1'b1};
  assign w_ma   = w_sgn ? {{N{i_a[N-1]}}, i_a} : {{N{1'b0}}, i_a};
  assign w_mb   = w_sgn ? {{N{i_b[N-1]}}, i_b} : {{N{1'b0}}, i_b};
  assign w_prod = w_ma * w_mb;

  always_comb begin
    o_out      = '0;
    o_cout     = 1'b0;
    o_overflow = 1'b0;
    case (op_base(i_op))
      ALU_ADD: begin
        o_out      = w_sum[N-1:0];
        o_cout     = w_sum[N];
        o_overflow = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
      end
      ALU_SUB: begin
        o_out      = w_dif[N-1:0];
        o_cout     = w_dif[N];
        o_overflow = (i_a[N-1] != i_b[N-1]) && (w_dif[N-1] != i_a[N-1]);
      end
      ALU_LSL: o_out = i_a << i_b;
      ALU_LSR: o_out = i_a >> i_b;
      ALU_ASR: o_out = N'($signed(i_a) >>> i_b);
      ALU_MUL: begin
        o_out = w_prod[N-1:0];
        if (w_sgn)
          o_overflow = !((&w_prod[2*N-1:N-1]) || !(|w_prod[2*N-1:N-1]));
        else
          o_overflow = |w_prod[2*N-1:N];
      end
      default: ;
    endcase
    o_sign = o_out[N-1];
    o_zero = (o_out == '0);
  end

endmodule

// File: rtl/alu_exec_div.sv
// Iterative restoring divider on unsigned magnitudes; one quotient bit per cycle.
module div_iter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_done,
  output logic [N-1:0] o_quotient
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic [N:0]    w_shift;
  logic [N:0]    w_trial;
  logic          w_ge;

  // r_quo starts as the dividend and fills with quotient bits from the right.
  // The remainder stays below the divisor, so the top bit of the N+1 bit
  // trial difference is exactly the borrow.
  assign w_shift = {r_rem, r_quo[N-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_ge    = !w_trial[N];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
      r_cnt <= CW'(N - 1);
      r_run <= 1'b1;
    end else if (r_run) begin
      r_rem <= w_ge ? w_trial[N-1:0] : w_shift[N-1:0];
      r_quo <= {r_quo[N-2:0], w_ge};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == '0) r_run <= 1'b0;
    end
  end

  assign o_done     = r_run && (r_cnt == '0);
  assign o_quotient = r_quo;

endmodule

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ops through alu, DIV through div_iter, one
// registered back-pressurable result port.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [5:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_cout,
  output logic         out_overflow,
  output logic         out_sign,
  output logic         out_zero,
  output logic         busy
);

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  exec_state_e  r_state, w_next;
  logic         r_out_valid;
  logic [N-1:0] r_result;
  logic         r_cout, r_ovf, r_sign, r_zero;
  logic         r_neg, r_dz, r_mn;

  logic [N-1:0] w_alu_out;
  logic         w_alu_cout, w_alu_ovf, w_alu_sign, w_alu_zero;
  logic         w_signed, w_is_div, w_accept, w_div_start, w_div_done;
  logic [N-1:0] w_mag_a, w_mag_b, w_quo, w_div_res;
  logic         w_div_ovf;

  assign w_signed    = (in_op & ALU_SIGNED) != 6'h00;
  assign w_is_div    = op_base(in_op) == ALU_DIV;
  assign in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_div_start = w_accept && w_is_div;
  assign w_mag_a     = (w_signed && in_a[N-1]) ? -in_a : in_a;
  assign w_mag_b     = (w_signed && in_b[N-1]) ? -in_b : in_b;

  alu #(.N(N)) u_alu (
    .i_a       (in_a),
    .i_b       (in_b),
    .i_op      (in_op),
    .i_cin     (in_cin),
    .o_out     (w_alu_out),
    .o_cout    (w_alu_cout),
    .o_overflow(w_alu_ovf),
    .o_sign    (w_alu_sign),
    .o_zero    (w_alu_zero)
  );

  div_iter #(.N(N)) u_div (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_div_start),
    .i_dividend(w_mag_a),
    .i_divisor (w_mag_b),
    .o_done    (w_div_done),
    .o_quotient(w_quo)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_div_start) w_next = S_DIV;
      S_DIV:   if (w_div_done) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Special cases override the divider's magnitude quotient.
  always_comb begin
    w_div_res = r_neg ? -w_quo : w_quo;
    w_div_ovf = 1'b0;
    if (r_dz) begin
      w_div_res = '1;
      w_div_ovf = 1'b1;
    end else if (r_mn) begin
      w_div_res = MOST_NEG;
      w_div_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg <= 1'b0;
      r_dz  <= 1'b0;
      r_mn  <= 1'b0;
    end else if (w_div_start) begin
      r_neg <= w_signed && (in_a[N-1] ^ in_b[N-1]);
      r_dz  <= (in_b == '0);
      r_mn  <= w_signed && (in_a == MOST_NEG) && (in_b == '1);
    end
  end

  // A DIV is only accepted with the output register empty or draining, so
  // the FIX load never lands on an unconsumed result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_sign      <= 1'b0;
      r_zero      <= 1'b0;
    end else if (r_state == S_FIX) begin
      r_out_valid <= 1'b1;
      r_result    <= w_div_res;
      r_cout      <= 1'b0;
      r_ovf       <= w_div_ovf;
      r_sign      <= w_div_res[N-1];
      r_zero      <= (w_div_res == '0);
    end else if (w_accept && !w_is_div) begin
      r_out_valid <= 1'b1;
      r_result    <= w_alu_out;
      r_cout      <= w_alu_cout;
      r_ovf       <= w_alu_ovf;
      r_sign      <= w_alu_sign;
      r_zero      <= w_alu_zero;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_result   = r_result;
  assign out_cout     = r_cout;
  assign out_overflow = r_ovf;
  assign out_sign     = r_sign;
  assign out_zero     = r_zero;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_exec.sv
// Directed test-plan steps followed by randomized traffic checked against an
// arithmetic reference model and an in-order scoreboard.
module tb_alu_exec;
  import alu_exec_pkg::*;

  localparam int N    = 8;
  localparam int UMOD = 1 << N;
  localparam int MAXS = (1 << (N - 1)) - 1;
  localparam int MINS = -(1 << (N - 1));

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [5:0]   in_op = '0;
  logic [N-1:0] in_a = '0, in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid, out_ready = 1'b0;
  logic [N-1:0] out_result;
  logic         out_cout, out_overflow, out_sign, out_zero, busy;

  always #5 clk = ~clk;

  alu_exec #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_cout(out_cout), .out_overflow(out_overflow), .out_sign(out_sign),
    .out_zero(out_zero), .busy(busy)
  );

  typedef struct packed {
    logic [N-1:0] res;
    logic cout, ovf, sgn, zero;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  function automatic exp_t model(input logic [5:0] op, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input logic cin);
    exp_t e;
    int ua, ub, sa, sb, r;
    logic sg;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sg = (op & ALU_SIGNED) != 6'h00;
    e  = '0;
    r  = 0;
    case (op & ~ALU_SIGNED)
      ALU_ADD: begin
        r = ua + ub + int'(cin);
        e.cout = (r >= UMOD);
        e.ovf  = (sa + sb + int'(cin) > MAXS) || (sa + sb + int'(cin) < MINS);
      end
      ALU_SUB: begin
        r = ua - ub;
        e.cout = (ua >= ub);
        e.ovf  = (sa - sb > MAXS) || (sa - sb < MINS);
      end
      ALU_LSL: r = (ub >= N) ? 0 : (ua << ub);
      ALU_LSR: r = (ub >= N) ? 0 : (ua >> ub);
      ALU_ASR: r = (ub >= N) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
      ALU_MUL: begin
        if (sg) begin
          r = sa * sb;
          e.ovf = (r > MAXS) || (r < MINS);
        end else begin
          r = ua * ub;
          e.ovf = (r >= UMOD);
        end
      end
      ALU_DIV: begin
        if (ub == 0) begin
          r = -1;
          e.ovf = 1'b1;
        end else if (sg && sa == MINS && sb == -1) begin
          r = MINS;
          e.ovf = 1'b1;
        end else if (sg) r = sa / sb;
        else             r = ua / ub;
      end
      default: r = 0;
    endcase
    e.res  = r[N-1:0];
    e.zero = (e.res == '0);
    e.sgn  = e.res[N-1];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".res"}, 32'(out_result), 32'(e.res));
    chk({tag, ".flags(c,v,s,z)"}, {28'd0, out_cout, out_overflow, out_sign, out_zero},
        {28'd0, e.cout, e.ovf, e.sgn, e.zero});
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic cin, input logic ordy);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_cin = cin; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Issue one op into an idle block, wait for the result, check it, consume it.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic cin, input int lit);
    exp_t e;
    int   k;
    e = model(op, a, b, cin);
    k = 1;
    drive(1'b1, op, a, b, cin, 1'b0);
    tick();
    drive(1'b0, op, a, b, cin, 1'b0);
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".latency"}, 32'(k), ((op & ~ALU_SIGNED) == ALU_DIV) ? 32'(N + 2) : 32'd1);
    chk_out(tag, e);
    if (lit >= 0) chk({tag, ".lit"}, 32'(out_result), 32'(lit));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    int          issued;
    logic [5:0]  ops [7];
    logic [5:0]  op;
    logic [N-1:0] a, b;
    logic        cin;
    ops = '{ALU_ADD, ALU_SUB, ALU_LSL, ALU_LSR, ALU_ASR, ALU_MUL, ALU_DIV};
    issued = 0;

    // reset state
    drive(1'b0, ALU_ADD, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.result", 32'(out_result), 32'd0);
    chk("rst.flags", {28'd0, out_cout, out_overflow, out_sign, out_zero}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    run_op("add255+1", ALU_ADD, 8'd255, 8'd1, 1'b0, 0);

    // back-to-back with writeback always ready
    drive(1'b1, ALU_ADD, 8'd1, 8'd1, 1'b0, 1'b1);
    tick();
    chk("b2b.v1", 32'(out_valid), 32'd1);
    chk("b2b.r1", 32'(out_result), 32'd2);
    drive(1'b1, ALU_ADD, 8'd127, 8'd127, 1'b0, 1'b1);
    #1;
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("b2b.v2", 32'(out_valid), 32'd1);
    chk("b2b.r2", 32'(out_result), 32'd254);
    drive(1'b0, ALU_ADD, '0, '0, 1'b0, 1'b1);
    tick();
    chk("b2b.drained", 32'(out_valid), 32'd0);

    // signed -7/3 with cycle-exact busy / in_ready / out_valid
    drive(1'b1, ALU_DIV | ALU_SIGNED, 8'hF9, 8'h03, 1'b0, 1'b1);
    #1;
    chk("sdiv.in_ready0", 32'(in_ready), 32'd1);
    for (int k = 1; k <= N + 2; k++) begin
      tick();
      if (k == 1) drive(1'b0, ALU_ADD, '0, '0, 1'b0, 1'b1);
      chk($sformatf("sdiv.busy@%0d", k), 32'(busy), 32'(k <= N + 1));
      chk($sformatf("sdiv.valid@%0d", k), 32'(out_valid), 32'(k == N + 2));
      chk($sformatf("sdiv.in_ready@%0d", k), 32'(in_ready), 32'(k == N + 2));
    end
    chk_out("sdiv", model(ALU_DIV | ALU_SIGNED, 8'hF9, 8'h03, 1'b0));
    chk("sdiv.lit", 32'(out_result), 32'hFE);
    tick();
    out_ready = 1'b0;

    run_op("udiv200/7", ALU_DIV, 8'd200, 8'd7, 1'b0, 28);
    run_op("sdiv-128/-1", ALU_DIV | ALU_SIGNED, 8'h80, 8'hFF, 1'b0, 8'h80);
    run_op("div5/0", ALU_DIV, 8'd5, 8'd0, 1'b0, 8'hFF);
    run_op("smul-3*7", ALU_MUL | ALU_SIGNED, 8'hFD, 8'd7, 1'b0, 8'hEB);
    run_op("asr", ALU_ASR, 8'hBA, 8'd2, 1'b0, 8'hEE);

    // back-pressure: result holds, issue stalls, then zero-bubble hand-over
    drive(1'b1, ALU_LSL, 8'h3A, 8'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, ALU_SUB, 8'd1, 8'd2, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp.hold@%0d", j), 32'(out_result), 32'hE8);
      chk($sformatf("bp.stall@%0d", j), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release", 32'(in_ready), 32'd1);
    tick();
    chk("bp.sub.valid", 32'(out_valid), 32'd1);
    chk_out("bp.sub", model(ALU_SUB, 8'd1, 8'd2, 1'b0));
    chk("bp.sub.lit", 32'(out_result), 32'hFF);
    drive(1'b0, ALU_ADD, '0, '0, 1'b0, 1'b1);
    tick();

    // reset mid-divide
    drive(1'b1, ALU_DIV, 8'd100, 8'd3, 1'b0, 1'b1);
    tick();
    drive(1'b0, ALU_ADD, '0, '0, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rdiv.busy", 32'(busy), 32'd0);
    chk("rdiv.valid", 32'(out_valid), 32'd0);
    chk("rdiv.in_ready", 32'(in_ready), 32'd1);
    for (int j = 0; j < 15; j++) begin
      tick();
      chk($sformatf("rdiv.none@%0d", j), 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // randomized traffic with random back-pressure
    for (int i = 0; i < 6000 && (issued < 300 || sb_q.size() > 0); i++) begin
      @(negedge clk);
      op  = ops[$urandom_range(0, 6)] | (($urandom_range(0, 1) == 1) ? ALU_SIGNED : 6'h00);
      a   = N'($urandom);
      b   = N'($urandom);
      if (((op & ~ALU_SIGNED) inside {ALU_LSL, ALU_LSR, ALU_ASR}) && $urandom_range(0, 3) != 0)
        b = N'($urandom_range(0, N + 1));
      cin = 1'($urandom);
      drive((issued < 300) && ($urandom_range(0, 2) != 0), op, a, b, cin,
            $urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        chk("rnd.pending", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk_out("rnd", e);
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(op, a, b, cin));
        issued++;
      end
    end
    chk("rnd.issued", 32'(issued), 32'd300);
    chk("rnd.drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
